// File: rtl/stb_sample_fifo.sv
//------------------------------------------------------------------------------
// stb_sample_fifo
//
// Rate-adaptation buffer in front of a strobe-paced sample stage. Samples come
// in from a valid/ready source at any rate. One sample leaves per stb_in pulse,
// so the output rate follows the rate-divider strobe. A prefill state machine
// holds the output back until PREFILL samples are stored, which absorbs
// start-up jitter. An empty FIFO on a running strobe is an underrun: the last
// sample is held, a pulse is raised, and a saturating counter is bumped.
//
// Ports
//   clk             clock
//   rst             synchronous, active-high reset
//   in_data         upstream sample
//   in_valid        in_data valid
//   in_ready        FIFO can accept (level != DEPTH), combinational
//   stb_in          one-cycle release strobe
//   out_data        registered output sample, held between strobes
//   out_stb         one-cycle pulse, one cycle after each stb_in
//   level           current occupancy, 0..DEPTH
//   running         1 = RUNNING, 0 = FILLING
//   underrun        one-cycle pulse on a RUNNING strobe with the FIFO empty
//   underrun_count  saturating count of underrun events
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module stb_sample_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4,
    parameter int PREFILL    = 8,
    parameter int UCNT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  stb_in,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_stb,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  running,
    output logic                  underrun,
    output logic [UCNT_WIDTH-1:0] underrun_count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_LVL   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] PREFILL_LVL = (DEPTH_LOG2 + 1)'(PREFILL);

    typedef enum logic {
        S_FILLING = 1'b0,
        S_RUNNING = 1'b1
    } state_t;

    logic [WIDTH-1:0]      mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    state_t                state_q, state_d;
    logic [WIDTH-1:0]      out_data_q, out_data_d;
    logic                  out_stb_q, out_stb_d;
    logic                  underrun_q, underrun_d;
    logic [UCNT_WIDTH-1:0] ucnt_q, ucnt_d;

    logic                  push;
    logic                  pop;
    logic                  empty_stb;

    function automatic logic [UCNT_WIDTH-1:0] sat_inc(input logic [UCNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_ready = (level_q != DEPTH_LVL);

    always_comb begin
        push      = in_valid && in_ready;
        // Pops only see registered occupancy, so a sample pushed this cycle
        // cannot be popped until the next one.
        pop       = (state_q == S_RUNNING) && stb_in && (level_q != '0);
        empty_stb = (state_q == S_RUNNING) && stb_in && (level_q == '0);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        state_d    = state_q;
        out_data_d = out_data_q;
        out_stb_d  = stb_in;
        underrun_d = 1'b0;
        ucnt_d     = ucnt_q;

        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            out_data_d = mem_q[rd_ptr_q];
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        case (state_q)
            S_FILLING: begin
                if (level_q >= PREFILL_LVL) begin
                    state_d = S_RUNNING;
                end
            end
            S_RUNNING: begin
                // Empty on a strobe: hold out_data, flag it and refill.
                if (empty_stb) begin
                    underrun_d = 1'b1;
                    ucnt_d     = sat_inc(ucnt_q);
                    state_d    = S_FILLING;
                end
            end
            default: state_d = S_FILLING;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            state_q    <= S_FILLING;
            out_data_q <= '0;
            out_stb_q  <= 1'b0;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_stb_q  <= out_stb_d;
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_data       = out_data_q;
    assign out_stb        = out_stb_q;
    assign level          = level_q;
    assign running        = (state_q == S_RUNNING);
    assign underrun       = underrun_q;
    assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_stb_sample_fifo.sv
`timescale 1ns/1ps

module tb_stb_sample_fifo;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        stb_in;
    logic [15:0] out_data;
    logic        out_stb;
    logic [4:0]  level;
    logic        running;
    logic        underrun;
    logic [7:0]  underrun_count;

    stb_sample_fifo #(
        .WIDTH(16), .DEPTH_LOG2(4), .PREFILL(8), .UCNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .stb_in(stb_in),
        .out_data(out_data), .out_stb(out_stb),
        .level(level), .running(running),
        .underrun(underrun), .underrun_count(underrun_count)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        u;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [15:0] d, input logic u);
        sbq.push_back('{d: d, u: u});
    endtask

    // Monitor: every out_stb must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_stb) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_stb", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                mon_e = sbq.pop_front();
                chk("out_data", 32'(out_data), 32'(mon_e.d));
                chk("underrun", 32'(underrun), 32'(mon_e.u));
            end
        end else if (!rst && underrun) begin
            chk("underrun_without_out_stb", 32'(underrun), 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    logic [15:0] t2_exp [12] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3,
                                 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd8};

    initial begin
        // Reset with inputs active
        rst = 1'b1; in_valid = 1'b1; stb_in = 1'b1; in_data = 16'h0055;
        tick(); tick();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_stb", 32'(out_stb), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_count", 32'(underrun_count), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0; in_valid = 1'b0; stb_in = 1'b0;

        // Prefill then drain to underrun: push 1..8, strobe every 4 cycles
        for (int t = 0; t <= 44; t++) begin
            in_valid = (t < 8);
            in_data  = 16'(t + 1);
            stb_in   = ((t % 4) == 0);
            if (stb_in) expect_out(t2_exp[t / 4], (t == 44));
            tick();
            if (t == 7) begin
                chk("prefill_level", 32'(level), 32'd8);
                chk("prefill_still_filling", 32'(running), 32'd0);
            end
            if (t == 8) chk("prefill_running", 32'(running), 32'd1);
        end
        in_valid = 1'b0; stb_in = 1'b0;
        chk("uflow_count", 32'(underrun_count), 32'd1);
        chk("uflow_running", 32'(running), 32'd0);
        chk("uflow_level", 32'(level), 32'd0);

        // Full: offer 17 samples with no strobe
        for (int t = 0; t <= 16; t++) begin
            in_valid = 1'b1;
            in_data  = 16'(101 + t);
            tick();
            if (t == 15) begin
                chk("full_level", 32'(level), 32'd16);
                chk("full_in_ready", 32'(in_ready), 32'd0);
            end
        end
        chk("full_17th_blocked", 32'(level), 32'd16);
        stb_in = 1'b1;
        expect_out(16'd101, 1'b0);
        tick();
        chk("full_after_pop_level", 32'(level), 32'd15);
        chk("full_after_pop_ready", 32'(in_ready), 32'd1);
        stb_in = 1'b0;
        tick();
        chk("full_17th_accepted", 32'(level), 32'd16);
        in_valid = 1'b0;

        // Drain to level 5 with back-to-back strobes
        for (int i = 0; i < 11; i++) begin
            stb_in = 1'b1;
            expect_out(16'(102 + i), 1'b0);
            tick();
        end
        chk("drain_level", 32'(level), 32'd5);

        // Simultaneous push and pop at level 5
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(201 + i);
            stb_in   = 1'b1;
            expect_out((i < 5) ? 16'(113 + i) : 16'(196 + i), 1'b0);
            tick();
            chk("pushpop_level", 32'(level), 32'd5);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stb_in = 1'b1;
            expect_out(16'(206 + i), 1'b0);
            tick();
        end
        stb_in = 1'b0;
        tick();
        chk("pushpop_drained", 32'(level), 32'd0);

        // Saturation: 300 more underruns (count starts at 1)
        for (int r = 1; r <= 300; r++) begin
            for (int k = 0; k < 8; k++) begin
                in_valid = 1'b1;
                in_data  = 16'(k + 1);
                tick();
            end
            in_valid = 1'b0;
            tick();
            for (int k = 0; k < 9; k++) begin
                stb_in = 1'b1;
                expect_out((k < 8) ? 16'(k + 1) : 16'd8, (k == 8));
                tick();
            end
            stb_in = 1'b0;
            if (r == 253) chk("sat_count_254", 32'(underrun_count), 32'd254);
            if (r == 254) chk("sat_count_255", 32'(underrun_count), 32'd255);
        end
        chk("sat_count_held", 32'(underrun_count), 32'd255);

        // Reset mid-stream
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(300 + k);
            tick();
        end
        chk("mid_level_before_rst", 32'(level), 32'd3);
        rst = 1'b1;
        tick();
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_count", 32'(underrun_count), 32'd0);
        chk("mid_rst_running", 32'(running), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("mid_rst_level_after", 32'(level), 32'd0);

        tick();
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
